// File: rtl/dds_channel_reader_if.sv
// Sample-memory read bus between a DDS channel reader and its waveform table.
// The reader owns the master modport; the memory side owns the slave modport.
interface dds_channel_reader_if #(
  parameter int ADDR_W = 10
);
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [11:0]       mem_data_i;

  modport master (
    output mem_rd_o,
    output mem_addr_o,
    input  mem_data_i
  );

  modport slave (
    input  mem_rd_o,
    input  mem_addr_o,
    output mem_data_i
  );
endinterface

// File: rtl/dds_channel_reader.sv
// DDS channel engine: each accepted strobe advances the phase accumulator,
// reads one table sample and registers it onto the DAC bus.
//   state | meaning
//   IDLE  | waiting for a sample strobe
//   FETCH | memory read strobe asserted for one cycle
//   WAIT  | counting down the memory read latency
module dds_channel_reader #(
  parameter int          ADDR_W    = 10,
  parameter int          MEM_LAT   = 1,
  parameter logic [11:0] IDLE_CODE = 12'h800
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic                 dds_en_i,
  input  logic                 dds_tick_i,
  input  logic [31:0]          dds_ftw_i,
  input  logic [31:0]          dds_pofs_i,
  input  logic                 dds_ovr_clr_i,
  dds_channel_reader_if.master mem_if,
  output logic [11:0]          dds_ch_o,
  output logic                 dds_upd_o,
  output logic                 dds_ovr_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} state_t;

  state_t            r_state, w_state_nx;
  logic [31:0]       r_acc, w_acc_nx, w_acc_base;
  logic [1:0]        r_cnt, w_cnt_nx;
  logic              r_en_q;
  logic              r_mem_rd, w_mem_rd_nx;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nx;
  logic [11:0]       r_ch, w_ch_nx;
  logic              r_upd, w_upd_nx;
  logic              r_ovr, w_ovr_nx;
  logic              w_en_rise;

  assign w_en_rise  = dds_en_i & ~r_en_q;
  // A tick in the enable cycle must already see the restarted accumulator.
  assign w_acc_base = w_en_rise ? 32'd0 : r_acc;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_en_q     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_ch       <= IDLE_CODE;
      r_upd      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_acc      <= w_acc_nx;
      r_cnt      <= w_cnt_nx;
      r_en_q     <= dds_en_i;
      r_mem_rd   <= w_mem_rd_nx;
      r_mem_addr <= w_mem_addr_nx;
      r_ch       <= w_ch_nx;
      r_upd      <= w_upd_nx;
      r_ovr      <= w_ovr_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_acc_nx      = w_acc_base;
    w_cnt_nx      = r_cnt;
    w_mem_rd_nx   = 1'b0;
    w_mem_addr_nx = r_mem_addr;
    w_ch_nx       = r_ch;
    w_upd_nx      = 1'b0;
    w_ovr_nx      = r_ovr;

    if (!dds_en_i) begin
      w_state_nx = S_IDLE;
      w_ch_nx    = IDLE_CODE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dds_tick_i) begin
            w_mem_addr_nx = ADDR_W'((w_acc_base + dds_pofs_i) >> (32 - ADDR_W));
            w_mem_rd_nx   = 1'b1;
            w_acc_nx      = w_acc_base + dds_ftw_i;
            w_state_nx    = S_FETCH;
          end
        end
        S_FETCH: begin
          w_cnt_nx   = 2'(MEM_LAT - 1);
          w_state_nx = S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            w_ch_nx    = mem_if.mem_data_i;
            w_upd_nx   = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_cnt_nx = r_cnt - 2'd1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end

    // A new overrun wins over a clear in the same cycle.
    if (dds_en_i && dds_tick_i && (r_state != S_IDLE))
      w_ovr_nx = 1'b1;
    else if (dds_ovr_clr_i)
      w_ovr_nx = 1'b0;
  end

  assign mem_if.mem_rd_o   = r_mem_rd;
  assign mem_if.mem_addr_o = r_mem_addr;
  assign dds_ch_o          = r_ch;
  assign dds_upd_o         = r_upd;
  assign dds_ovr_o         = r_ovr;

endmodule

// File: tb/tb_dds_channel_reader.sv
// Directed bench for dds_channel_reader: one instance with 1-cycle memory
// latency and one with 4-cycle latency, each fed by a table returning addr+0x100.
module tb_dds_channel_reader;

  logic        clk = 1'b0;
  logic        rst, en, tick, clr;
  logic [31:0] ftw, pofs;

  logic [11:0] ch1, ch4;
  logic        upd1, upd4, ovr1, ovr4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dds_channel_reader_if #(.ADDR_W(10)) mif1 ();
  dds_channel_reader_if #(.ADDR_W(10)) mif4 ();

  dds_channel_reader #(.ADDR_W(10), .MEM_LAT(1), .IDLE_CODE(12'h800)) dut1 (
    .sys_clk_i(clk), .sys_rst_i(rst), .dds_en_i(en), .dds_tick_i(tick),
    .dds_ftw_i(ftw), .dds_pofs_i(pofs), .dds_ovr_clr_i(clr),
    .mem_if(mif1.master), .dds_ch_o(ch1), .dds_upd_o(upd1), .dds_ovr_o(ovr1));

  dds_channel_reader #(.ADDR_W(10), .MEM_LAT(4), .IDLE_CODE(12'h800)) dut4 (
    .sys_clk_i(clk), .sys_rst_i(rst), .dds_en_i(en), .dds_tick_i(tick),
    .dds_ftw_i(ftw), .dds_pofs_i(pofs), .dds_ovr_clr_i(clr),
    .mem_if(mif4.master), .dds_ch_o(ch4), .dds_upd_o(upd4), .dds_ovr_o(ovr4));

  // Table models; idle cycles return 0 so stale data is distinguishable.
  logic [11:0] p1;
  logic [11:0] p4 [4];
  always @(posedge clk) begin
    p1    <= mif1.mem_rd_o ? 12'h100 + 12'(mif1.mem_addr_o) : 12'h000;
    p4[0] <= mif4.mem_rd_o ? 12'h100 + 12'(mif4.mem_addr_o) : 12'h000;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign mif1.mem_data_i = p1;
  assign mif4.mem_data_i = p4[3];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Accepted tick on dut1 with 10-cycle spacing.
  task automatic do_tick(input string tag, input logic [9:0] exp_addr, input logic [11:0] exp_data);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check({tag, "_rd"}, 32'(mif1.mem_rd_o), 32'd1);
    check({tag, "_addr"}, 32'(mif1.mem_addr_o), 32'(exp_addr));
    cyc();
    check({tag, "_noupd"}, 32'(upd1), 32'd0);
    cyc();
    check({tag, "_upd"}, 32'(upd1), 32'd1);
    check({tag, "_ch"}, 32'(ch1), 32'(exp_data));
    repeat (7) cyc();
  endtask

  task automatic reenable();
    en = 1'b0;
    cyc();
    check("dis_ch", 32'(ch1), 32'h800);
    en = 1'b1;
  endtask

  initial begin
    logic saw_upd;
    rst = 1'b1; en = 1'b1; tick = 1'b0; clr = 1'b0; ftw = '0; pofs = '0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    check("rst_ch", 32'(ch1), 32'h800);
    check("rst_rd", 32'(mif1.mem_rd_o), 32'd0);
    check("rst_ovr", 32'(ovr1), 32'd0);
    check("rst_upd", 32'(upd1), 32'd0);

    // Forward stepping, one entry per tick.
    ftw = 32'h0040_0000;
    do_tick("fwd0", 10'd0, 12'h100);
    do_tick("fwd1", 10'd1, 12'h101);
    do_tick("fwd2", 10'd2, 12'h102);

    // Reverse stepping from a restarted accumulator.
    ftw = 32'hFFC0_0000;
    reenable();
    do_tick("rev0", 10'd0, 12'h100);
    do_tick("rev1", 10'd1023, 12'h4FF);
    do_tick("rev2", 10'd1022, 12'h4FE);

    // Half-cycle phase offset, then a zero tuning word holds the address.
    pofs = 32'h8000_0000;
    reenable();
    do_tick("pofs", 10'd512, 12'h300);
    ftw = 32'h0;
    do_tick("hold0", 10'd511, 12'h2FF);
    do_tick("hold1", 10'd511, 12'h2FF);

    // Overrun: second tick two cycles later is dropped.
    ftw = 32'h0040_0000; pofs = 32'h0;
    en = 1'b0; cyc(); en = 1'b1; cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    check("ovr_addr0", 32'(mif1.mem_addr_o), 32'd0);
    cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    check("ovr_set", 32'(ovr1), 32'd1);
    check("ovr_ch", 32'(ch1), 32'h100);
    cyc();
    do_tick("ovr_next", 10'd1, 12'h101);
    check("ovr_sticky", 32'(ovr1), 32'd1);
    clr = 1'b1; cyc(); clr = 1'b0;
    check("ovr_clr", 32'(ovr1), 32'd0);

    // Ticks exactly three cycles apart are both accepted.
    tick = 1'b1; cyc(); tick = 1'b0;
    check("sp3_addr_a", 32'(mif1.mem_addr_o), 32'd2);
    cyc(); cyc();
    check("sp3_ch_a", 32'(ch1), 32'h102);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("sp3_rd_b", 32'(mif1.mem_rd_o), 32'd1);
    check("sp3_addr_b", 32'(mif1.mem_addr_o), 32'd3);
    check("sp3_noovr", 32'(ovr1), 32'd0);
    cyc(); cyc();
    check("sp3_ch_b", 32'(ch1), 32'h103);
    repeat (4) cyc();

    // Clear coincident with a new overrun leaves the flag set.
    tick = 1'b1; cyc();
    check("clr_race_addr", 32'(mif1.mem_addr_o), 32'd4);
    clr = 1'b1; cyc(); tick = 1'b0; clr = 1'b0;
    check("clr_race_ovr", 32'(ovr1), 32'd1);
    cyc();
    check("clr_race_ch", 32'(ch1), 32'h104);
    clr = 1'b1; cyc(); clr = 1'b0;
    check("clr_race_clr", 32'(ovr1), 32'd0);
    repeat (4) cyc();

    // Disable in the cycle after the read strobe discards the fetch.
    tick = 1'b1; cyc(); tick = 1'b0;
    check("dis_rd", 32'(mif1.mem_rd_o), 32'd1);
    cyc();
    en = 1'b0;
    cyc();
    check("dis_ch_idle", 32'(ch1), 32'h800);
    check("dis_noupd", 32'(upd1), 32'd0);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("dis_tick_rd", 32'(mif1.mem_rd_o), 32'd0);
    check("dis_tick_ovr", 32'(ovr1), 32'd0);
    cyc();
    pofs = 32'h4000_0000;
    en = 1'b1;
    do_tick("reen", 10'd256, 12'h200);

    // Reset during WAIT on the 4-cycle-latency instance.
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    check("l4_rd", 32'(mif4.mem_rd_o), 32'd1);
    check("l4_addr", 32'(mif4.mem_addr_o), 32'd256);
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    check("l4_rst_rd", 32'(mif4.mem_rd_o), 32'd0);
    check("l4_rst_addr", 32'(mif4.mem_addr_o), 32'd0);
    check("l4_rst_ch", 32'(ch4), 32'h800);
    check("l4_rst_upd", 32'(upd4), 32'd0);
    saw_upd = 1'b0;
    repeat (6) begin
      cyc();
      if (upd4) saw_upd = 1'b1;
    end
    check("l4_no_stale_upd", 32'(saw_upd), 32'd0);
    check("l4_ch_end", 32'(ch4), 32'h800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_channel_reader.md
# dds_channel_reader

Per-channel DDS sample engine that consumes the single-cycle sample strobes from the waveform clock and turns them into DAC codes. On each accepted strobe it advances a 32-bit phase accumulator, issues one read to the channel's waveform sample memory, and registers the returned 12-bit sample onto the DAC bus. One instance sits between each waveform-clock output (`wc_clk_1_o` / `wc_clk_2_o`) and the corresponding `dds_ch1_o` / `dds_ch2_o` pins.

## Interface

Parameters:
- `ADDR_W`, 10: sample memory address width; the table holds 2^ADDR_W entries.
- `MEM_LAT`, 1: read latency of the sample memory in clocks; legal range 1..4.
- `IDLE_CODE`, 12'h800: DAC code driven while the channel is disabled (midscale).

Ports:
- `sys_clk_i`, input, 1: system clock.
- `sys_rst_i`, input, 1: system reset. Synchronous to `sys_clk_i`, active-high.
- `dds_en_i`, input, 1: channel enable, level.
- `dds_tick_i`, input, 1: sample strobe from the waveform clock, one cycle wide.
- `dds_ftw_i`, input, 32: frequency tuning word, sampled on each accepted tick.
- `dds_pofs_i`, input, 32: phase offset, sampled on each accepted tick.
- `dds_ovr_clr_i`, input, 1: clears `dds_ovr_o`.
- `mem_rd_o`, output, 1: sample memory read strobe.
- `mem_addr_o`, output, ADDR_W: sample memory address.
- `mem_data_i`, input, 12: sample memory read data, valid MEM_LAT cycles after the `mem_rd_o` cycle.
- `dds_ch_o`, output, 12: DAC code.
- `dds_upd_o`, output, 1: one-cycle pulse in the first cycle `dds_ch_o` carries a new sample.
- `dds_ovr_o`, output, 1: sticky overrun flag.

## Operation

- Reset values: acc=0, state=IDLE, `mem_rd_o`=0, `mem_addr_o`=0, `dds_ch_o`=IDLE_CODE, `dds_upd_o`=0, `dds_ovr_o`=0.

State machine:
- IDLE: waits for a tick.
  - On `dds_tick_i`=1 with `dds_en_i`=1: `mem_addr_o` <= (acc + `dds_pofs_i`)[31:32-ADDR_W]; `mem_rd_o` <= 1; acc <= acc + `dds_ftw_i` (mod 2^32); go to FETCH.
- FETCH: lasts one cycle with `mem_rd_o`=1.
  - Next edge: `mem_rd_o` <= 0; wait counter <= MEM_LAT-1; go to WAIT.
- WAIT: counts down to 0.
  - On the edge at count 0: `dds_ch_o` <= `mem_data_i`; `dds_upd_o` <= 1; go to IDLE.

Rules:
- The address uses the pre-increment accumulator, so the first sample after enable reads address `dds_pofs_i`[31:32-ADDR_W].
- Arithmetic: the accumulator wraps silently. ftw=0 holds the current address. ftw=2^(32-ADDR_W) steps one table entry per tick.
- Enable rising edge (`dds_en_i` 0 -> 1, registered compare): acc <= 0. A tick in that same cycle is accepted and uses acc=0.
- Disable (`dds_en_i`=0 in any state):
  - Next edge: state=IDLE, `mem_rd_o`=0, `dds_ch_o`=IDLE_CODE, `dds_upd_o`=0.
  - An in-flight read is discarded. Ticks are ignored and never set overrun.
- Overrun: a tick while enabled and the state is not IDLE is dropped. The accumulator is not advanced and `dds_ovr_o` <= 1.
  - `dds_ovr_clr_i` clears the flag. A clear and a new overrun in the same cycle leave the flag set.
- `dds_ftw_i` / `dds_pofs_i` changes only take effect at the next accepted tick.
- `sys_rst_i` mid-fetch: all state returns to reset values on the next edge, and the returned data is discarded.

## Timing

For a tick accepted in cycle T:
- `mem_rd_o`=1 and `mem_addr_o` valid in cycle T+1.
- `mem_data_i` is sampled at the end of cycle T+1+MEM_LAT.
- `dds_ch_o` is updated and `dds_upd_o`=1 in cycle T+2+MEM_LAT.

Throughput and overrun:
- The FSM is back in IDLE in cycle T+2+MEM_LAT, so a tick in that cycle is accepted.
- Minimum tick spacing is MEM_LAT+2 cycles. Ticks in cycles T+1 .. T+1+MEM_LAT cause overrun.

Output stability:
- `dds_ch_o` changes only on update, disable, or reset.
- `mem_addr_o` holds its last value between reads.

## Test plan

1. Reset with `dds_en_i`=1 and no ticks -> `dds_ch_o`=12'h800, `mem_rd_o`=0, `dds_ovr_o`=0.
2. ADDR_W=10, MEM_LAT=1, ftw=0x0040_0000, pofs=0, memory returns data=addr+0x100; ticks every 10 cycles -> addresses 0,1,2,... Tick at T gives `mem_rd_o` at T+1 and `dds_ch_o`=0x100,0x101,... with `dds_upd_o` at T+3.
3. ftw=0xFFC0_0000 (step -1 entry) -> addresses 0,1023,1022. Then pofs=0x8000_0000 after re-enable -> first address 512.
4. Ticks 2 cycles apart (MEM_LAT=1) -> second tick dropped, `dds_ovr_o`=1, address sequence unchanged. `dds_ovr_clr_i` pulse -> flag 0. Ticks exactly 3 cycles apart -> no overrun.
5. Drop `dds_en_i` in the cycle after `mem_rd_o` -> next cycle `dds_ch_o`=12'h800, no `dds_upd_o`. Re-enable with a same-cycle tick -> address = pofs slice (acc restarted at 0).
6. Assert `sys_rst_i` during WAIT with MEM_LAT=4 -> all outputs at reset values next cycle; no update occurs when the stale data returns.
